// File: rtl/curtain_motor_ctrl.sv
// Curtain motor H-bridge controller: decodes the PIO command word, debounces the
// end-of-travel switches and enforces dead time, run timeout and sensor-fault lockout.
module curtain_motor_ctrl #(
    parameter int DEADTIME_CYC = 50000,
    parameter int DEBOUNCE_CYC = 250000,
    parameter int MAX_RUN_CYC  = 1500000000,
    parameter int CNT_W        = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] cmd,
    input  logic       lim_open_raw,
    input  logic       lim_closed_raw,
    output logic       motor_open,
    output logic       motor_close,
    output logic [3:0] status
);

    typedef enum logic [2:0] {IDLE, DEAD, OPENING, CLOSING, FAULT} state_t;

    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEADTIME_CYC - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(MAX_RUN_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    // Index 0 is the fully-open switch, index 1 the fully-closed switch.
    logic [1:0]       lim_raw;
    logic [1:0]       sync_1;
    logic [1:0]       sync_2;
    logic [1:0]       lim_deb;
    logic [CNT_W-1:0] deb_cnt [2];

    logic             at_open;
    logic             at_closed;
    logic             req_open;
    logic             req_close;
    logic             sensor_fault;

    state_t           state;
    state_t           next_state;
    logic             target_open;
    logic [CNT_W-1:0] state_cnt;

    assign lim_raw = {lim_closed_raw, lim_open_raw};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1  <= '0;
            sync_2  <= '0;
            lim_deb <= '0;
            for (int i = 0; i < 2; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync_1 <= lim_raw;
            sync_2 <= sync_1;
            for (int i = 0; i < 2; i++) begin
                if (sync_2[i] == lim_deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] >= DEB_LAST) begin
                    lim_deb[i] <= sync_2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign at_open      = lim_deb[0];
    assign at_closed    = lim_deb[1];
    assign req_open     = (cmd == 3'b101);
    assign req_close    = (cmd == 3'b110);
    assign sensor_fault = at_open & at_closed;

    // One counter serves dead time and run time; it restarts on every state change.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            target_open <= 1'b0;
            state_cnt   <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && next_state == DEAD) begin
                target_open <= req_open;
            end
            if (next_state != state) begin
                state_cnt <= '0;
            end else if (state_cnt != CNT_MAX) begin
                state_cnt <= state_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req_open && !at_open) begin
                    next_state = DEAD;
                end else if (req_close && !at_closed) begin
                    next_state = DEAD;
                end
            end
            DEAD: begin
                if (target_open ? !req_open : !req_close) begin
                    next_state = IDLE;
                end else if (state_cnt >= DEAD_LAST) begin
                    next_state = target_open ? OPENING : CLOSING;
                end
            end
            OPENING: begin
                if (at_open || !req_open) begin
                    next_state = IDLE;
                end else if (state_cnt >= RUN_LAST) begin
                    next_state = FAULT;
                end
            end
            CLOSING: begin
                if (at_closed || !req_close) begin
                    next_state = IDLE;
                end else if (state_cnt >= RUN_LAST) begin
                    next_state = FAULT;
                end
            end
            FAULT: begin
                if (!cmd[2]) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        // Both switches made at once cannot be real travel, so lock out regardless.
        if (sensor_fault) begin
            next_state = FAULT;
        end
    end

    always_comb begin
        motor_open  = (state == OPENING);
        motor_close = (state == CLOSING);
        status      = {state == FAULT,
                       (state == DEAD) || (state == OPENING) || (state == CLOSING),
                       at_open,
                       at_closed};
    end

endmodule

// File: tb/tb_curtain_motor_ctrl.sv
// Scoreboard bench for curtain_motor_ctrl: stimulus queues expected outputs per edge,
// a monitor compares them shortly after each rising edge.
module tb_curtain_motor_ctrl;

    localparam int DEADTIME_CYC = 4;
    localparam int DEBOUNCE_CYC = 3;
    localparam int MAX_RUN_CYC  = 20;

    logic       clk;
    logic       reset;
    logic [2:0] cmd;
    logic       lim_open_raw;
    logic       lim_closed_raw;
    logic       motor_open;
    logic       motor_close;
    logic [3:0] status;

    typedef struct {
        int         at_edge;
        logic       mo;
        logic       mc;
        logic [3:0] st;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    edge_n   = 0;
    int    checks   = 0;
    int    failures = 0;

    curtain_motor_ctrl #(
        .DEADTIME_CYC(DEADTIME_CYC),
        .DEBOUNCE_CYC(DEBOUNCE_CYC),
        .MAX_RUN_CYC (MAX_RUN_CYC),
        .CNT_W       (32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd           (cmd),
        .lim_open_raw  (lim_open_raw),
        .lim_closed_raw(lim_closed_raw),
        .motor_open    (motor_open),
        .motor_close   (motor_close),
        .status        (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare every expectation due on this edge, and watch for shoot-through.
    always begin
        @(posedge clk);
        edge_n++;
        #1;
        checks++;
        if (motor_open && motor_close) begin
            failures++;
            $display("[TB] FAIL both_drives edge %0d: got open=1 close=1, expected at most one", edge_n);
        end
        while (exp_q.size() > 0 && exp_q[0].at_edge <= edge_n) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if (e.at_edge < edge_n) begin
                failures++;
                $display("[TB] FAIL %s: expectation for edge %0d not checked (now %0d)", nm, e.at_edge, edge_n);
            end else if (motor_open !== e.mo || motor_close !== e.mc || status !== e.st) begin
                failures++;
                $display("[TB] FAIL %s edge %0d: got open=%0b close=%0b status=%04b, expected open=%0b close=%0b status=%04b",
                         nm, edge_n, motor_open, motor_close, status, e.mo, e.mc, e.st);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic apply_stimulus(input logic [2:0] c, input logic lo, input logic lc);
        cmd            = c;
        lim_open_raw   = lo;
        lim_closed_raw = lc;
    endtask

    // Queue the outputs expected right after the d-th rising edge from now.
    task automatic check_output(input int d, input logic mo, input logic mc,
                                input logic [3:0] st, input string nm);
        exp_t e;
        e.at_edge = edge_n + d;
        e.mo      = mo;
        e.mc      = mc;
        e.st      = st;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        apply_stimulus(3'b000, 1'b0, 1'b0);
        @(negedge clk);
        check_output(1, 0, 0, 4'b0000, "reset_state");
        wait_edges(2);
        reset = 1'b0;

        // Open run, stopped by the open limit; a further open request is ignored.
        apply_stimulus(3'b101, 1'b0, 1'b0);
        check_output(1, 0, 0, 4'b0100, "open_dead_first");
        check_output(4, 0, 0, 4'b0100, "open_dead_last");
        check_output(5, 1, 0, 4'b0100, "open_drive");
        wait_edges(7);
        apply_stimulus(3'b101, 1'b1, 1'b0);
        check_output(4, 1, 0, 4'b0100, "open_lim_pending");
        check_output(5, 1, 0, 4'b0110, "open_at_open");
        check_output(6, 0, 0, 4'b0010, "open_stop");
        check_output(8, 0, 0, 4'b0010, "open_ignored");
        wait_edges(8);
        apply_stimulus(3'b000, 1'b0, 1'b0);
        check_output(4, 0, 0, 4'b0010, "open_lim_hold");
        check_output(5, 0, 0, 4'b0000, "open_lim_release");
        wait_edges(6);

        // Reversal goes through IDLE and a fresh dead time.
        apply_stimulus(3'b101, 1'b0, 1'b0);
        check_output(5, 1, 0, 4'b0100, "rev_opening");
        wait_edges(7);
        apply_stimulus(3'b110, 1'b0, 1'b0);
        check_output(1, 0, 0, 4'b0000, "rev_off");
        check_output(2, 0, 0, 4'b0100, "rev_dead");
        check_output(5, 0, 0, 4'b0100, "rev_dead_last");
        check_output(6, 0, 1, 4'b0100, "rev_close");
        wait_edges(7);
        apply_stimulus(3'b000, 1'b0, 1'b0);
        check_output(1, 0, 0, 4'b0000, "rev_stop");
        wait_edges(2);

        // Run timeout latches FAULT until enable drops.
        apply_stimulus(3'b101, 1'b0, 1'b0);
        check_output(24, 1, 0, 4'b0100, "to_last_run");
        check_output(25, 0, 0, 4'b1000, "to_fault");
        check_output(28, 0, 0, 4'b1000, "to_hold");
        wait_edges(28);
        apply_stimulus(3'b000, 1'b0, 1'b0);
        check_output(1, 0, 0, 4'b0000, "to_clear");
        wait_edges(2);

        // Short limit bounce is filtered; both limits made forces FAULT.
        apply_stimulus(3'b101, 1'b0, 1'b0);
        wait_edges(6);
        apply_stimulus(3'b101, 1'b1, 1'b0);
        wait_edges(2);
        apply_stimulus(3'b101, 1'b0, 1'b0);
        check_output(6, 1, 0, 4'b0100, "bounce_no_stop");
        wait_edges(6);
        apply_stimulus(3'b101, 1'b1, 1'b1);
        check_output(5, 1, 0, 4'b0111, "sensor_pending");
        check_output(6, 0, 0, 4'b1011, "sensor_fault");
        wait_edges(6);
        apply_stimulus(3'b000, 1'b1, 1'b1);
        check_output(2, 0, 0, 4'b1011, "sensor_hold");
        wait_edges(2);
        apply_stimulus(3'b000, 1'b0, 1'b0);
        check_output(5, 0, 0, 4'b1000, "sensor_latched");
        check_output(6, 0, 0, 4'b0000, "sensor_clear");
        wait_edges(6);

        // Close request toward a made limit is ignored; reset mid-run kills the drive.
        apply_stimulus(3'b000, 1'b0, 1'b1);
        check_output(5, 0, 0, 4'b0001, "closed_limit");
        wait_edges(5);
        apply_stimulus(3'b110, 1'b0, 1'b1);
        check_output(1, 0, 0, 4'b0001, "closed_ignore_1");
        check_output(3, 0, 0, 4'b0001, "closed_ignore_3");
        wait_edges(3);
        apply_stimulus(3'b110, 1'b0, 1'b0);
        check_output(5, 0, 0, 4'b0000, "closed_released");
        check_output(6, 0, 0, 4'b0100, "closed_dead");
        check_output(10, 0, 1, 4'b0100, "closing");
        wait_edges(11);
        reset = 1'b1;
        check_output(1, 0, 0, 4'b0000, "reset_mid_run");
        wait_edges(1);
        reset = 1'b0;
        apply_stimulus(3'b000, 1'b0, 1'b0);
        wait_edges(2);

        // Invalid words never start a run and stop one in progress.
        apply_stimulus(3'b111, 1'b0, 1'b0);
        check_output(1, 0, 0, 4'b0000, "inv111_idle_1");
        check_output(4, 0, 0, 4'b0000, "inv111_idle_4");
        wait_edges(4);
        apply_stimulus(3'b011, 1'b0, 1'b0);
        check_output(2, 0, 0, 4'b0000, "inv011_idle");
        wait_edges(2);
        apply_stimulus(3'b101, 1'b0, 1'b0);
        check_output(5, 1, 0, 4'b0100, "inv_pre_open");
        wait_edges(6);
        apply_stimulus(3'b111, 1'b0, 1'b0);
        check_output(1, 0, 0, 4'b0000, "inv111_stop");
        wait_edges(2);
        apply_stimulus(3'b101, 1'b0, 1'b0);
        wait_edges(6);
        apply_stimulus(3'b001, 1'b0, 1'b0);
        check_output(1, 0, 0, 4'b0000, "disable_stop");
        wait_edges(2);
        apply_stimulus(3'b101, 1'b0, 1'b0);
        wait_edges(2);
        apply_stimulus(3'b000, 1'b0, 1'b0);
        check_output(1, 0, 0, 4'b0000, "dead_abort");
        wait_edges(3);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL queue_drained: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
